orb_write_arbiter: RTL and testbench
====================================

ORB_WRITE_ARBITER -- requirements
Module: orb_write_arbiter

Interface
REQ-001 Parameter QUOTA, default 16: maximum words accepted per requester per half-frame (range 1..31).
REQ-002 clk  input  1  system clock (80 MHz domain); all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 SW  input  1  ping-pong half-frame select from the orbit framer; asynchronous to clk.
REQ-005 empty  input  4  per-requester FIFO empty flag; bit i=1 means requester i has no word.
REQ-006 fifoData  input  48  FIFO read data; requester i on bits [12i+11:12i]; valid one cycle after its rdAck.
REQ-007 baseAddr  input  44  per-requester orbit-RAM base address; requester i on bits [11i+10:11i].
REQ-008 rdAck  output  4  one-hot FIFO read request, one cycle wide.
REQ-009 wAddr  output  11  orbit-RAM write address.
REQ-010 orbWord  output  12  orbit-RAM write data.
REQ-011 WE  output  1  orbit-RAM write enable, one cycle per word.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 overrun  output  4  sticky per-requester flag: word received beyond QUOTA in current half-frame.

Function
REQ-014 SW shall pass through a 2-flop synchronizer; any edge of the synchronized value shall set an internal switch-pending flag.
REQ-015 FSM states: IDLE, READ, LATCH, WRITE; all transitions on clk rising edge.
REQ-016 IDLE: if switch-pending, clear all offset counters and switch-pending, stay IDLE that cycle; else if any empty bit is 0, grant one requester and go READ; else stay IDLE.
REQ-017 Arbitration shall be round-robin: search starts at requester (last_grant+1) mod 4; last_grant resets to 3, so requester 0 has first priority after reset.
REQ-018 READ: rdAck[grant]=1 for exactly this cycle; go LATCH.
REQ-019 LATCH: capture fifoData[grant] into orbWord, compute wAddr = baseAddr[grant] + offset[grant], modulo 2048 (11-bit wrap); go WRITE.
REQ-020 WRITE: WE=1 if offset[grant] < QUOTA, then offset[grant] increments; else WE=0, word discarded, overrun[grant] set; go IDLE.
REQ-021 Latency: grant in IDLE at cycle N -> rdAck at N+1 -> WE at N+3; one word per 4 cycles maximum throughput.
REQ-022 orbWord and wAddr shall hold their values outside WRITE; WE and rdAck are 0 outside their states.
REQ-023 Offset counters are 5 bits, one per requester; they saturate at QUOTA and never wrap.
REQ-024 A SW edge arriving mid-transaction shall not abort it; the word completes into the old offset and counters clear at the next IDLE.
REQ-025 Two SW edges before the next IDLE shall collapse into a single clear.
REQ-026 overrun bits clear only on rst.
REQ-027 An empty bit asserting while its requester is in READ/LATCH/WRITE shall not affect the transaction in flight.

Reset
REQ-028 On rst=1 at a clock edge: FSM=IDLE, rdAck=0, WE=0, wAddr=0, orbWord=0, busy=0, overrun=0, all offsets=0, last_grant=3, switch-pending=0, synchronizer flops loaded with 0.
REQ-029 rst asserted mid-transaction shall abort it with no WE pulse on the following cycle.
REQ-030 After rst release, the first SW sample of 1 shall count as an edge and set switch-pending.

Verification
REQ-031 Requester 0 holds 3 words 0x111,0x222,0x333, baseAddr0=100 -> WE at wAddr 100,101,102 with that data, 4 cycles apart, rdAck[0] 2 cycles before each WE.
REQ-032 All four requesters non-empty continuously -> grant order 0,1,2,3,0,... and each requester gets one write per 16 cycles.
REQ-033 QUOTA=16, requester 1 supplies 18 words -> 16 WE pulses, 2 rdAck with no WE, overrun=4'b0010.
REQ-034 baseAddr2=2046, 4 words -> wAddr 2046,2047,0,1.
REQ-035 SW toggles while requester 3 is in LATCH -> that word written at old offset; next word written at baseAddr3+0.
REQ-036 rst asserted on the READ cycle -> no WE follows, all outputs 0 next cycle, next grant goes to requester 0.

Source files
------------

// File: rtl/orb_write_arbiter.sv
// rtl/orb_write_arbiter.sv - round-robin arbiter moving requester FIFO words into orbit RAM
module orb_write_arbiter #(
  parameter int QUOTA = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SW,
  input  logic [3:0]  empty,
  input  logic [47:0] fifoData,
  input  logic [43:0] baseAddr,
  output logic [3:0]  rdAck,
  output logic [10:0] wAddr,
  output logic [11:0] orbWord,
  output logic        WE,
  output logic        busy,
  output logic [3:0]  overrun
);

  typedef enum logic [1:0] {IDLE, READ, LATCH, WRITE} state_t;

  localparam logic [4:0] QUOTA_W = 5'(QUOTA);

  state_t      state_q, state_d;
  logic        sw_meta_q, sw_sync_q, sw_prev_q;
  logic        pend_q, pend_d;
  logic [1:0]  last_q, last_d;
  logic [4:0]  off_q [4];
  logic [4:0]  off_d [4];
  logic [10:0] waddr_q, waddr_d;
  logic [11:0] word_q, word_d;
  logic [3:0]  ovr_q, ovr_d;

  logic        sw_edge;
  logic        rr_found;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_cand;
  logic        in_quota;

  // SW comes from another clock domain; sw_prev_q lets a 1 sampled right after reset count as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      sw_prev_q <= 1'b0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
    end
  end

  assign sw_edge = sw_sync_q ^ sw_prev_q;

  // Round-robin search starting one past the most recent grant
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_q;
    rr_cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_q + 2'(k);
      if (!rr_found && !empty[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // last_q doubles as the in-flight grant while the FSM is outside IDLE
  assign in_quota = off_q[last_q] < QUOTA_W;

  // Next-state and outputs; a pending half-frame switch is only acted on in IDLE
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | sw_edge;
    last_d  = last_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    word_d  = word_q;
    ovr_d   = ovr_q;
    rdAck   = 4'b0000;
    WE      = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (pend_q || sw_edge) begin
          for (int i = 0; i < 4; i++) off_d[i] = 5'd0;
        end else if (rr_found) begin
          last_d  = rr_pick;
          state_d = READ;
        end
      end
      READ: begin
        rdAck   = 4'b0001 << last_q;
        state_d = LATCH;
      end
      LATCH: begin
        word_d  = fifoData[12*last_q +: 12];
        waddr_d = baseAddr[11*last_q +: 11] + 11'(off_q[last_q]);
        state_d = WRITE;
      end
      WRITE: begin
        if (in_quota) begin
          WE            = 1'b1;
          off_d[last_q] = off_q[last_q] + 5'd1;
        end else begin
          ovr_d[last_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      last_q  <= 2'd3;
      waddr_q <= 11'd0;
      word_q  <= 12'd0;
      ovr_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) off_q[i] <= 5'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      waddr_q <= waddr_d;
      word_q  <= word_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < 4; i++) off_q[i] <= off_d[i];
    end
  end

  assign busy    = (state_q != IDLE);
  assign wAddr   = waddr_q;
  assign orbWord = word_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_orb_write_arbiter.sv
// tb/tb_orb_write_arbiter.sv - scoreboard bench for orb_write_arbiter
module tb_orb_write_arbiter;

  localparam int Q = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        SW;
  logic [3:0]  empty = 4'hF;
  logic [47:0] fifoData = '0;
  logic [43:0] baseAddr;
  logic [3:0]  rdAck;
  logic [10:0] wAddr;
  logic [11:0] orbWord;
  logic        WE;
  logic        busy;
  logic [3:0]  overrun;

  orb_write_arbiter #(.QUOTA(Q)) dut (
    .clk(clk), .rst(rst), .SW(SW), .empty(empty), .fifoData(fifoData),
    .baseAddr(baseAddr), .rdAck(rdAck), .wAddr(wAddr), .orbWord(orbWord),
    .WE(WE), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int req;
    bit we;
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   fq[4][$];
  int   mq[4][$];
  int   m_off[4];
  int   m_base[4];
  int   m_last;
  int   m_ovr;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t pend;
  bit   pend_v = 0;
  int   pend_cyc = 0;
  int   last_rd = -100;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Emulated requester FIFOs: pop on a read request, present data, refresh empty flags
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rdAck[i] && fq[i].size() > 0) fifoData[12*i +: 12] = 12'(fq[i].pop_front());
    for (int i = 0; i < 4; i++) empty[i] = (fq[i].size() == 0);
  end

  // Monitor: each read request claims the next expected transaction, its write is due 2 cycles later
  always @(negedge clk) begin
    if (rst) begin
      pend_v = 0;
    end else begin
      if (rdAck != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rdack: got %b expected none", rdAck);
        end else begin
          pend = exp_q.pop_front();
          check("rdack_grant", int'(rdAck), 1 << pend.req);
          check("rdack_spacing", int'((cyc - last_rd) >= 4), 1);
          pend_v = 1;
          pend_cyc = cyc;
        end
        last_rd = cyc;
      end
      if (pend_v && cyc == pend_cyc + 2) begin
        check("we", int'(WE), int'(pend.we));
        if (pend.we) begin
          check("waddr", int'(wAddr), pend.addr);
          check("orbword", int'(orbWord), pend.data);
        end
        pend_v = 0;
      end else if (WE) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we: got 1 expected 0 at waddr %0d", wAddr);
      end
    end
  end

  task automatic set_base(input int r, input int a);
    m_base[r] = a % 2048;
    baseAddr[11*r +: 11] = 11'(a);
  endtask

  task automatic load(input int r, input int w);
    fq[r].push_back(w & 12'hFFF);
    mq[r].push_back(w & 12'hFFF);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_off[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_last = 3;
    m_ovr = 0;
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      fq[i].delete();
    end
    exp_q.delete();
  endtask

  // Serve up to n queued words in round-robin order, each requester writing base+offset until it hits the quota
  task automatic model_run(input int n);
    for (int s = 0; s < n; s++) begin
      int r;
      exp_t e;
      r = -1;
      for (int k = 1; k <= 4; k++)
        if (r < 0 && mq[(m_last + k) % 4].size() > 0) r = (m_last + k) % 4;
      if (r < 0) break;
      m_last = r;
      e.req = r;
      e.data = mq[r].pop_front();
      if (m_off[r] < Q) begin
        e.we = 1;
        e.addr = (m_base[r] + m_off[r]) % 2048;
        m_off[r]++;
      end else begin
        e.we = 0;
        e.addr = 0;
        m_ovr = m_ovr | (1 << r);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pend_v || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drain"}, int'(t < 3000), 1);
    check({name, "_overrun"}, int'(overrun), m_ovr);
  endtask

  task automatic toggle_sw();
    SW = ~SW;
    repeat (6) @(negedge clk);
    model_clear();
  endtask

  task automatic wait_rdack(input int mask, input string name);
    int t;
    t = 0;
    while ((int'(rdAck) & mask) == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, int'(t < 200), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rdack"}, int'(rdAck), 0);
    check({name, "_we"}, int'(WE), 0);
    check({name, "_waddr"}, int'(wAddr), 0);
    check({name, "_orbword"}, int'(orbWord), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    rst = 1'b1;
    SW = 1'b0;
    baseAddr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // three words from requester 0 at base 100
    set_base(0, 100);
    load(0, 'h111);
    load(0, 'h222);
    load(0, 'h333);
    model_run(100);
    wait_drain("seq3");

    // all four requesters busy at once
    set_base(1, 500);
    set_base(2, 1000);
    set_base(3, 1500);
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 4; r++) load(r, (r << 8) | w);
    model_run(100);
    wait_drain("all4");

    // half-frame switch while requester 3 is in LATCH
    set_base(3, 700);
    load(3, 'hAAA);
    load(3, 'hBBB);
    model_run(1);
    wait_rdack(4'b1000, "midswitch_wait");
    @(negedge clk);
    SW = ~SW;
    model_clear();
    model_run(100);
    wait_drain("midswitch");

    // address wrap at the top of orbit RAM
    toggle_sw();
    set_base(2, 2046);
    for (int w = 0; w < 4; w++) load(2, 'h700 + w);
    model_run(100);
    wait_drain("wrap");

    // requester 1 exceeds its quota
    toggle_sw();
    for (int w = 0; w < Q + 2; w++) load(1, 'h400 + w);
    model_run(100);
    wait_drain("quota");
    check("quota_overrun_bits", int'(overrun), 4'b0010);

    // randomized rounds with occasional half-frame switches
    for (int round = 0; round < 6; round++) begin
      if ($urandom_range(0, 1) == 1) toggle_sw();
      for (int r = 0; r < 4; r++) set_base(r, int'($urandom_range(0, 2047)));
      for (int r = 0; r < 4; r++) begin
        int n;
        n = int'($urandom_range(0, 8));
        for (int w = 0; w < n; w++) load(r, int'($urandom_range(0, 4095)));
      end
      model_run(1000);
      wait_drain("random");
    end

    // reset on the READ cycle aborts the transaction
    load(2, 'h5A5);
    model_run(1);
    wait_rdack(4'b0100, "abort_wait");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_base(0, 10);
    set_base(2, 20);
    load(0, 'h0C3);
    load(2, 'h3C0);
    model_run(100);
    wait_drain("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
